// File: rtl/player_cmd_arbiter.sv
// Player command arbiter: turns damage, heal and move requests into one
// 16-bit player instruction at a time, held until the datapath accepts it.
module player_cmd_arbiter #(
   parameter logic [7:0]  HEAL_AMT   = 8'd10,
   parameter int unsigned MOVE_DIV   = 4,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dmg_pulse,
   input  logic [7:0]  dmg_val,
   input  logic        heal_pulse,
   input  logic        move_req,
   input  logic [1:0]  move_dir,
   output logic [15:0] insn,
   output logic        insn_valid,
   input  logic        insn_ready,
   output logic        busy
);

   localparam logic [3:0] OP_HPY     = 4'b0001;
   localparam logic [3:0] OP_DPY     = 4'b0010;
   localparam logic [3:0] OP_MOV     = 4'b0101;
   localparam logic [7:0] MOVE_LAST  = 8'(MOVE_DIV - 1);
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_insn;
   logic [15:0] w_insn_nxt;
   logic        r_insn_valid;
   logic        w_valid_nxt;
   logic [7:0]  r_pend_dmg;
   logic        r_heal_pend;
   logic [7:0]  r_starve_cnt;
   logic [7:0]  r_move_cnt;
   logic        r_move_token;

   logic        w_sel_hpy;
   logic        w_sel_dpy;
   logic        w_sel_mov;
   logic        w_accept;
   logic        w_acc_hpy;
   logic        w_acc_dpy;
   logic        w_acc_mov;
   logic        w_starved;
   logic        w_wrap;
   logic [7:0]  w_dmg_base;
   logic [8:0]  w_dmg_sum;
   logic [7:0]  w_dmg_nxt;

   assign w_accept  = (r_state == S_ISSUE) && insn_ready;
   assign w_acc_hpy = w_accept && (r_insn[15:12] == OP_HPY);
   assign w_acc_dpy = w_accept && (r_insn[15:12] == OP_DPY);
   assign w_acc_mov = w_accept && (r_insn[15:12] == OP_MOV);
   assign w_starved = r_heal_pend && (r_starve_cnt >= STARVE_LIM);
   assign w_wrap    = (r_move_cnt >= MOVE_LAST);

   // A damage pulse in the selection cycle starts a fresh accumulation.
   assign w_dmg_base = w_sel_dpy ? 8'd0 : r_pend_dmg;
   assign w_dmg_sum  = {1'b0, w_dmg_base} + {1'b0, dmg_val};
   assign w_dmg_nxt  = (dmg_pulse && (dmg_val != 8'd0)) ?
                       (w_dmg_sum[8] ? 8'hFF : w_dmg_sum[7:0]) : w_dmg_base;

   always_comb begin
      w_state_nxt = r_state;
      w_insn_nxt  = r_insn;
      w_valid_nxt = r_insn_valid;
      w_sel_hpy   = 1'b0;
      w_sel_dpy   = 1'b0;
      w_sel_mov   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_heal_pend && (w_starved || (r_pend_dmg == 8'd0))) begin
               w_sel_hpy   = 1'b1;
               w_insn_nxt  = {OP_HPY, HEAL_AMT, 4'b0000};
               w_valid_nxt = 1'b1;
               w_state_nxt = S_ISSUE;
            end else if (r_pend_dmg != 8'd0) begin
               w_sel_dpy   = 1'b1;
               w_insn_nxt  = {OP_DPY, r_pend_dmg, 4'b0000};
               w_valid_nxt = 1'b1;
               w_state_nxt = S_ISSUE;
            end else if (move_req && r_move_token) begin
               w_sel_mov   = 1'b1;
               w_insn_nxt  = {OP_MOV, 6'b000000, move_dir, 4'b0000};
               w_valid_nxt = 1'b1;
               w_state_nxt = S_ISSUE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (insn_ready) begin
               w_insn_nxt  = 16'h0000;
               w_valid_nxt = 1'b0;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_ISSUE;
            end
         end
         default: begin
            w_insn_nxt  = 16'h0000;
            w_valid_nxt = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Wrap and accept on the same edge: the accept wins, so MOVs keep their spacing.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_insn       <= 16'h0000;
         r_insn_valid <= 1'b0;
         r_pend_dmg   <= 8'd0;
         r_heal_pend  <= 1'b0;
         r_starve_cnt <= 8'd0;
         r_move_cnt   <= 8'd0;
         r_move_token <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_insn       <= w_insn_nxt;
         r_insn_valid <= w_valid_nxt;
         r_pend_dmg   <= w_dmg_nxt;
         r_heal_pend  <= (r_heal_pend && !w_sel_hpy) || heal_pulse;
         if (w_acc_hpy) begin
            r_starve_cnt <= 8'd0;
         end else if (w_acc_dpy && r_heal_pend && (r_starve_cnt < STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
         end else begin
            r_starve_cnt <= r_starve_cnt;
         end
         r_move_cnt <= w_wrap ? 8'd0 : (r_move_cnt + 8'd1);
         if (w_acc_mov) begin
            r_move_token <= 1'b0;
         end else if (w_wrap) begin
            r_move_token <= 1'b1;
         end else begin
            r_move_token <= r_move_token;
         end
      end
   end

   assign insn       = r_insn;
   assign insn_valid = r_insn_valid;
   assign busy       = (r_pend_dmg != 8'd0) || r_heal_pend || r_insn_valid;

endmodule

// File: tb/tb_player_cmd_arbiter.sv
// Self-checking bench for player_cmd_arbiter: directed vector table, hand
// sequences for starvation and move pacing, and randomized traffic vs a model.
module tb_player_cmd_arbiter;

   localparam int MOVE_DIV   = 4;
   localparam int STARVE_MAX = 3;
   localparam int HEAL_AMT   = 10;

   logic        clk;
   logic        reset;
   logic        dmg_pulse;
   logic [7:0]  dmg_val;
   logic        heal_pulse;
   logic        move_req;
   logic [1:0]  move_dir;
   logic [15:0] insn;
   logic        insn_valid;
   logic        insn_ready;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int          m_dmg;
   bit          m_heal;
   int          m_starve;
   int          m_edges;
   bit          m_token;
   bit          m_valid;
   logic [15:0] m_insn;

   player_cmd_arbiter #(
      .HEAL_AMT  (8'd10),
      .MOVE_DIV  (MOVE_DIV),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .dmg_pulse (dmg_pulse),
      .dmg_val   (dmg_val),
      .heal_pulse(heal_pulse),
      .move_req  (move_req),
      .move_dir  (move_dir),
      .insn      (insn),
      .insn_valid(insn_valid),
      .insn_ready(insn_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        dp;
      logic [7:0]  dv;
      logic        hp;
      logic        rdy;
      logic [15:0] e_insn;
      logic        e_valid;
      logic        e_busy;
   } vec_t;

   vec_t tbl [24];

   task automatic drive(input logic r, input logic dp, input logic [7:0] dv,
                        input logic hp, input logic mr, input logic [1:0] md,
                        input logic rdy);
      reset = r; dmg_pulse = dp; dmg_val = dv; heal_pulse = hp;
      move_req = mr; move_dir = md; insn_ready = rdy;
   endtask

   // Model: instruction = op*4096 + arg*16, damage saturates at 255,
   // a move token appears every MOVE_DIV edges after reset.
   task automatic model_edge();
      bit acc, pick_h, pick_d, pick_m, wrap;
      int base;
      int op;
      if (reset) begin
         m_dmg = 0; m_heal = 0; m_starve = 0; m_edges = 0;
         m_token = 0; m_valid = 0; m_insn = 16'h0000;
         return;
      end
      m_edges = m_edges + 1;
      wrap   = (m_edges % MOVE_DIV) == 0;
      acc    = m_valid && insn_ready;
      pick_h = 0; pick_d = 0; pick_m = 0;
      if (!m_valid) begin
         if (m_heal && (m_dmg == 0 || m_starve >= STARVE_MAX)) pick_h = 1;
         else if (m_dmg != 0) pick_d = 1;
         else if (move_req && m_token) pick_m = 1;
      end
      if (acc) begin
         op = int'(m_insn) / 4096;
         if (op == 1) m_starve = 0;
         else if (op == 2 && m_heal && m_starve < STARVE_MAX) m_starve = m_starve + 1;
         if (op == 5) m_token = 0;
         else if (wrap) m_token = 1;
         m_valid = 0;
         m_insn  = 16'h0000;
      end else if (wrap) begin
         m_token = 1;
      end
      if (pick_h) begin m_valid = 1; m_insn = 16'(1 * 4096 + HEAL_AMT * 16); end
      if (pick_d) begin m_valid = 1; m_insn = 16'(2 * 4096 + m_dmg * 16); end
      if (pick_m) begin m_valid = 1; m_insn = 16'(5 * 4096 + int'(move_dir) * 16); end
      base = pick_d ? 0 : m_dmg;
      if (dmg_pulse && dmg_val != 8'd0)
         m_dmg = (base + int'(dmg_val) > 255) ? 255 : base + int'(dmg_val);
      else
         m_dmg = base;
      m_heal = (m_heal && !pick_h) || heal_pulse;
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic step();
      logic exp_busy;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      exp_busy = (m_dmg != 0) || m_heal || m_valid;
      n_vec = n_vec + 1;
      if (insn !== m_insn || insn_valid !== m_valid || busy !== exp_busy) begin
         n_err = n_err + 1;
         $display("FAIL model t=%0t: insn=%h valid=%b busy=%b, required insn=%h valid=%b busy=%b",
                  $time, insn, insn_valid, busy, m_insn, m_valid, exp_busy);
      end
   endtask

   task automatic check(input string name, input int got, input int want);
      n_vec = n_vec + 1;
      if (got != want) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   initial begin
      int   ops [$];
      int   first_hpy;
      int   n_mov;
      int   last_mov;

      //            rst   dp    dv      hp    rdy   insn      v     busy
      tbl[0]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 8'd25,  1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 16'h2190, 1'b1, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 8'd5,   1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 16'h2050, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 16'h10A0, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 16'h2C80, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 8'd100, 1'b0, 1'b0, 16'h2C80, 1'b1, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 16'h2C80, 1'b1, 1'b1};
      tbl[14] = '{1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 16'h2C80, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 16'h2FF0, 1'b1, 1'b1};
      tbl[17] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[19] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 16'h10A0, 1'b1, 1'b1};
      tbl[20] = '{1'b0, 1'b1, 8'd7,   1'b1, 1'b0, 16'h10A0, 1'b1, 1'b1};
      tbl[21] = '{1'b1, 1'b1, 8'd9,   1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
      tbl[22] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
      tbl[23] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};

      drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0);
      @(negedge clk);

      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].rst, tbl[i].dp, tbl[i].dv, tbl[i].hp, 1'b0, 2'd0, tbl[i].rdy);
         step();
         n_vec = n_vec + 1;
         if (insn !== tbl[i].e_insn || insn_valid !== tbl[i].e_valid || busy !== tbl[i].e_busy) begin
            n_err = n_err + 1;
            $display("FAIL table[%0d]: insn=%h valid=%b busy=%b, required insn=%h valid=%b busy=%b",
                     i, insn, insn_valid, busy, tbl[i].e_insn, tbl[i].e_valid, tbl[i].e_busy);
         end
      end

      // Heal starved by continuous damage: three DPY grants, then HPY.
      drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b1);
      step();
      drive(1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 2'd0, 1'b1);
      step();
      for (int c = 0; c < 16; c++) begin
         drive(1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 2'd0, 1'b1);
         step();
         if (insn_valid) ops.push_back(int'(insn[15:12]));
      end
      first_hpy = -1;
      foreach (ops[k]) if (first_hpy < 0 && ops[k] == 1) first_hpy = k;
      check("starve_first_hpy", first_hpy, STARVE_MAX);
      for (int k = 0; k < STARVE_MAX && k < ops.size(); k++) check("starve_dpy_op", ops[k], 2);

      // Move pacing: left held, one MOV per MOVE_DIV cycles.
      drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b1);
      step();
      n_mov = 0;
      last_mov = -100;
      for (int c = 0; c < 40; c++) begin
         drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 2'd3, 1'b1);
         step();
         if (insn_valid) begin
            check("mov_insn", int'(insn), 16'h5030);
            if (c - last_mov < MOVE_DIV) check("mov_spacing", c - last_mov, MOVE_DIV);
            last_mov = c;
            n_mov = n_mov + 1;
         end
      end
      check("mov_count", n_mov, 9);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom_range(0, 149) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
               ($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)),
               ($urandom_range(0, 2) != 0));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/player_cmd_arbiter.md
PLAYER_CMD_ARBITER -- requirements
Module: player_cmd_arbiter

Interface
REQ-001 Parameter HEAL_AMT, default 8'd10, heal amount placed in HPY argument.
REQ-002 Parameter MOVE_DIV, default 4, minimum cycles between issued MOV instructions (legal range 1..255).
REQ-003 Parameter STARVE_MAX, default 3, consecutive DPY grants allowed while a heal is pending.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 dmg_pulse  input  1  one-cycle damage request from bullet collision logic.
REQ-007 dmg_val  input  8  damage amount, sampled when dmg_pulse=1.
REQ-008 heal_pulse  input  1  one-cycle heal request.
REQ-009 move_req  input  1  level; player wants to move this cycle.
REQ-010 move_dir  input  2  direction: 0=up, 1=right, 2=down, 3=left.
REQ-011 insn  output  16  instruction {op[15:12], arg[11:4], 4'b0000}.
REQ-012 insn_valid  output  1  insn holds a valid instruction.
REQ-013 insn_ready  input  1  player datapath accepts insn when insn_valid=1.
REQ-014 busy  output  1  high while any request is pending or insn_valid=1.

Function
REQ-015 Op codes SHALL be HPY=4'b0001, DPY=4'b0010, MOV=4'b0101; idle insn SHALL be 16'h0000.
REQ-016 Pending damage SHALL be an 8-bit accumulator: on dmg_pulse with dmg_val!=0, pend_dmg <= min(pend_dmg + dmg_val, 255); dmg_val=0 pulses SHALL be ignored.
REQ-017 heal_pulse SHALL set a heal-pending flag; repeated pulses while pending SHALL NOT queue extra heals.
REQ-018 A free-running counter SHALL count 0..MOVE_DIV-1 and set move_token when it wraps; move_token SHALL clear only when a MOV is accepted.
REQ-019 FSM states: IDLE (insn_valid=0), ISSUE (insn_valid=1, insn held stable until accepted).
REQ-020 In IDLE, each cycle the arbiter SHALL select in priority DPY (pend_dmg!=0), then HPY (heal pending), then MOV (move_req=1 and move_token=1), register insn, and go to ISSUE; with nothing eligible it SHALL stay IDLE.
REQ-021 Exception: if heal is pending and STARVE_MAX consecutive DPY grants have been accepted, HPY SHALL be selected over DPY; the starve count SHALL clear on any HPY accept.
REQ-022 DPY argument SHALL be pend_dmg at selection; pend_dmg SHALL be zeroed at selection, and dmg_pulse in the same cycle SHALL start the new accumulation (no loss).
REQ-023 HPY argument SHALL be HEAL_AMT; heal flag clears at selection; heal_pulse in that cycle SHALL re-set it.
REQ-024 MOV argument SHALL be {6'b0, move_dir} sampled at selection.
REQ-025 In ISSUE, insn_valid=1 and insn_ready=1 SHALL return to IDLE on the next edge with insn_valid=0; insn_ready while IDLE SHALL be ignored.
REQ-026 Latency: request captured at edge E, insn_valid high after edge E+1 when IDLE; at most one instruction accepted per two cycles.
REQ-027 Pending requests SHALL continue to be captured/accumulated while in ISSUE.
REQ-028 busy SHALL be (pend_dmg!=0) | heal pending | insn_valid.

Reset
REQ-029 While reset=1 at an edge: insn=0, insn_valid=0, pend_dmg=0, heal flag=0, starve count=0, move counter=0, move_token=0, state=IDLE.
REQ-030 Reset during ISSUE SHALL drop insn_valid on that edge and discard all pending requests; reset SHALL override simultaneous pulses.

Verification
REQ-031 dmg_pulse with dmg_val=25, insn_ready=1 -> insn=16'h2190, insn_valid one cycle, then IDLE.
REQ-032 dmg_pulse 200 then 100 while insn_ready=0 -> first insn arg 200; after accept, second insn arg 255 (saturated).
REQ-033 heal_pulse and dmg_pulse(5) same cycle -> DPY arg 5 issued first, then HPY 16'h10A0.
REQ-034 heal pending, dmg_pulse(1) every cycle, insn_ready=1 -> exactly 3 DPY accepts then HPY.
REQ-035 move_req=1, move_dir=3 held, MOVE_DIV=4, insn_ready=1 -> insn=16'h5030 accepted no more often than every 4 cycles.
REQ-036 reset asserted while insn_valid=1 with pending heal -> next cycle insn_valid=0, busy=0, no HPY issued after reset releases.
